// File: rtl/run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : run_ctrl
//  Brief    : MIPS32 run controller - stretched reset release, pause gating,
//             cycle budget and multi-source halt with sticky end-of-run status.
//  Revision : 1.0
// ============================================================================
module run_ctrl #(
    parameter int RST_CYCLES = 3,
    parameter int MAX_CYCLES = 50,
    parameter int CNT_W      = 32,
    parameter int N_HALT     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_HALT-1:0]        halt_i,
    input  logic                     pause_i,
    output logic                     core_rst_o,
    output logic                     run_o,
    output logic [CNT_W-1:0]         cycle_cnt_o,
    output logic                     done_o,
    output logic                     timeout_o,
    output logic [$clog2(N_HALT):0]  halt_src_o
);

    localparam int                c_src_w    = $clog2(N_HALT) + 1;
    localparam logic [7:0]        c_rst_last = 8'(RST_CYCLES - 1);
    localparam bit                c_tmo_en   = (MAX_CYCLES != 0);
    localparam logic [CNT_W-1:0]  c_tmo_last = CNT_W'((MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [7:0]           r_rst_cnt;
    logic [7:0]           w_rst_cnt_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic                 r_timeout;
    logic                 w_timeout_nxt;
    logic [c_src_w-1:0]   r_src;
    logic [c_src_w-1:0]   w_src_nxt;
    logic [c_src_w-1:0]   w_halt_src;
    logic                 w_halt_any;
    logic                 w_tmo_hit;

    // Lowest-numbered requester wins; reported as index+1 so 0 means "none".
    always_comb begin
        w_halt_src = '0;
        for (int i = N_HALT - 1; i >= 0; i--) begin
            if (halt_i[i]) begin
                w_halt_src = c_src_w'(i + 1);
            end
        end
    end

    assign w_halt_any = |halt_i;
    assign w_tmo_hit  = c_tmo_en && (r_cnt == c_tmo_last);
    assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_rst_cnt_nxt = r_rst_cnt;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = r_timeout;
        w_src_nxt     = r_src;
        case (r_state)
            S_HOLD: begin
                if (r_rst_cnt == c_rst_last) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt + 8'd1;
                end
            end
            S_RUN: begin
                // Halt and timeout may coincide; both are recorded.
                if (w_halt_any || w_tmo_hit) begin
                    w_cnt_nxt   = w_cnt_inc;
                    w_state_nxt = S_DONE;
                    if (w_halt_any) begin
                        w_src_nxt = w_halt_src;
                    end
                    if (w_tmo_hit) begin
                        w_timeout_nxt = 1'b1;
                    end
                end else if (pause_i) begin
                    w_state_nxt = S_PAUSE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_PAUSE: begin
                if (!pause_i) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_HOLD;
            r_rst_cnt <= 8'd0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
            r_src     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rst_cnt <= w_rst_cnt_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
            r_src     <= w_src_nxt;
        end
    end

    // Status is decoded straight from the state register, so no input reaches an output.
    assign core_rst_o  = (r_state == S_HOLD);
    assign run_o       = (r_state == S_RUN);
    assign done_o      = (r_state == S_DONE);
    assign cycle_cnt_o = r_cnt;
    assign timeout_o   = r_timeout;
    assign halt_src_o  = r_src;

endmodule
`default_nettype wire
